// File: rtl/button_event_detect.sv
// Turns debounced button levels into one-cycle press/release/long-press/repeat pulses,
// one independent three-state machine per channel.
module button_event_detect #(
  parameter int unsigned W           = 1,
  parameter int unsigned LongDepth   = 8,
  parameter int unsigned RepeatDepth = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sw_in,
  output logic [W-1:0] o_press,
  output logic [W-1:0] o_release,
  output logic [W-1:0] o_long_press,
  output logic [W-1:0] o_repeat,
  output logic [W-1:0] o_held_long
);

  typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

  for (genvar gi = 0; gi < W; gi++) begin : g_ch
    state_e                 r_state, w_state_d;
    logic [LongDepth-1:0]   r_lcnt, w_lcnt_d;
    logic [RepeatDepth-1:0] r_rcnt, w_rcnt_d;
    logic                   r_prev;
    logic                   r_press, r_release, r_long, r_repeat;
    logic                   w_press_d, w_release_d, w_long_d, w_repeat_d;
    logic                   w_sw;

    assign w_sw = i_sw_in[gi];

    always_comb begin
      w_state_d   = r_state;
      w_lcnt_d    = r_lcnt;
      w_rcnt_d    = r_rcnt;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      w_long_d    = 1'b0;
      w_repeat_d  = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_sw && !r_prev) begin
            w_press_d = 1'b1;
            w_lcnt_d  = '0;
            w_state_d = StPressed;
          end
        end
        // Release is tested first so it wins over a counter reaching all ones.
        StPressed: begin
          if (!w_sw) begin
            w_release_d = 1'b1;
            w_state_d   = StIdle;
          end else if (&r_lcnt) begin
            w_long_d  = 1'b1;
            w_rcnt_d  = '0;
            w_state_d = StHeld;
          end else begin
            w_lcnt_d = r_lcnt + 1'b1;
          end
        end
        StHeld: begin
          if (!w_sw) begin
            w_release_d = 1'b1;
            w_state_d   = StIdle;
          end else if (&r_rcnt) begin
            w_repeat_d = 1'b1;
            w_rcnt_d   = '0;
          end else begin
            w_rcnt_d = r_rcnt + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state   <= StIdle;
        r_lcnt    <= '0;
        r_rcnt    <= '0;
        r_prev    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_d;
        r_lcnt    <= w_lcnt_d;
        r_rcnt    <= w_rcnt_d;
        r_prev    <= w_sw;
        r_press   <= w_press_d;
        r_release <= w_release_d;
        r_long    <= w_long_d;
        r_repeat  <= w_repeat_d;
      end
    end

    assign o_press[gi]      = r_press;
    assign o_release[gi]    = r_release;
    assign o_long_press[gi] = r_long;
    assign o_repeat[gi]     = r_repeat;
    assign o_held_long[gi]  = (r_state == StHeld);
  end

endmodule

// File: tb/tb_button_event_detect.sv
// Scoreboard bench: a hold-time model predicts every cycle's outputs; a monitor checks them.
module tb_button_event_detect;
  localparam int unsigned W  = 4;
  localparam int unsigned LD = 3;
  localparam int unsigned RD = 2;
  localparam int L = 1 << LD;
  localparam int R = 1 << RD;

  logic         clk, rst_n;
  logic [W-1:0] sw;
  logic [W-1:0] o_press, o_release, o_long, o_repeat, o_held;

  button_event_detect #(.W(W), .LongDepth(LD), .RepeatDepth(RD)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sw_in     (sw),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_long_press(o_long),
    .o_repeat    (o_repeat),
    .o_held_long (o_held)
  );

  typedef struct packed {
    logic [W-1:0] p, r, l, rp, h;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel tracks whether it is active and how many edges it has been held.
  initial begin
    logic [W-1:0] m_prev;
    int           m_k   [W];
    bit           m_act [W];
    exp_t         e;
    m_prev = '0;
    for (int i = 0; i < W; i++) begin m_k[i] = 0; m_act[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_prev = '0;
        for (int i = 0; i < W; i++) begin m_k[i] = 0; m_act[i] = 0; end
      end else begin
        e = '0;
        for (int i = 0; i < W; i++) begin
          if (m_act[i]) begin
            if (!sw[i]) begin
              e.r[i]   = 1'b1;
              m_act[i] = 0;
            end else begin
              m_k[i]++;
              if (m_k[i] == L) e.l[i] = 1'b1;
              else if (m_k[i] > L && ((m_k[i] - L) % R) == 0) e.rp[i] = 1'b1;
            end
          end else if (sw[i] && !m_prev[i]) begin
            e.p[i]   = 1'b1;
            m_act[i] = 1;
            m_k[i]   = 0;
          end
          e.h[i] = m_act[i] && (m_k[i] >= L);
        end
        m_prev = sw;
        q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e = '0;
        q.delete();
      end else if (q.size() > 0) begin
        e = q.pop_front();
      end else begin
        e = '0;
      end
      a = {o_press, o_release, o_long, o_repeat, o_held};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got p=%b r=%b l=%b rp=%b h=%b, expected p=%b r=%b l=%b rp=%b h=%b",
                 cyc, a.p, a.r, a.l, a.rp, a.h, e.p, e.r, e.l, e.rp, e.h);
      end
    end
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    sw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    sw    = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    hold('0, 2);
    hold(4'b0001, 3);  hold('0, 4);   // short press
    hold(4'b0001, 20); hold('0, 4);   // long press with repeats
    hold(4'b0001, 8);  hold('0, 4);   // release exactly when long press would fire
    hold(4'b0001, 1);  hold('0, 3);   // single-cycle press
    hold(4'b0001, 2);  hold(4'b0011, 3); hold(4'b0111, 1); hold(4'b1111, 20);
    hold(4'b1110, 5);  hold(4'b1100, 3); hold('0, 4);
    // Reset in the middle of a long hold while the button stays down.
    hold(4'b0001, 15);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_press, o_release, o_long, o_repeat, o_held} !== '0) begin
      n_fail++;
      $display("FAIL reset state: p=%b r=%b l=%b rp=%b h=%b",
               o_press, o_release, o_long, o_repeat, o_held);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_cnt = 0;
    while (!o_press[0] && wait_cnt < 5) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (!o_press[0]) begin
      n_fail++;
      $display("FAIL press after reset: wait expired after %0d cycles", wait_cnt);
    end
    hold(4'b0001, 12); hold('0, 3);
    for (int i = 0; i < 300; i++) begin
      hold(4'($urandom_range(0, 15)), $urandom_range(1, 20));
    end
    hold('0, 3);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
